// File: rtl/seq_mult_unit.sv
// Sequential unsigned multiplier: repeated addition of max(A,B), min(A,B) times,
// with early exit on a zero operand and a busy/done handshake.
module seq_mult_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StAcc,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [2*WIDTH-1:0]   f_q, f_d;

    logic                 a_ge_b;
    logic [WIDTH-1:0]     max_ab;
    logic [WIDTH-1:0]     min_ab;

    // Loop on the smaller operand so the iteration count is min(A,B).
    assign a_ge_b = (a_i >= b_i);
    assign max_ab = a_ge_b ? a_i : b_i;
    assign min_ab = a_ge_b ? b_i : a_i;

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        q_d     = q_q;
        f_d     = f_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    p_d     = {{WIDTH{1'b0}}, max_ab};
                    q_d     = min_ab;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                f_d     = '0;
                state_d = (q_q == '0) ? StDone : StAcc;
            end
            StAcc: begin
                if (q_q != '0) begin
                    f_d = f_q + p_q;
                    q_d = q_q - WIDTH'(1);
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= StIdle;
            p_q     <= '0;
            q_q     <= '0;
            f_q     <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            q_q     <= q_d;
            f_q     <= f_d;
        end
    end

    assign busy_o    = (state_q == StLoad) || (state_q == StAcc);
    assign done_o    = (state_q == StDone);
    assign product_o = f_q;

endmodule

// File: tb/tb_seq_mult_unit.sv
// Directed self-checking bench for seq_mult_unit at WIDTH=8.
module tb_seq_mult_unit;

    logic        clk_in;
    logic        rst_n_in;
    logic        start_i;
    logic [7:0]  a_i;
    logic [7:0]  b_i;
    logic        busy_o;
    logic        done_o;
    logic [15:0] product_o;

    int total = 0;
    int bad   = 0;

    seq_mult_unit #(.WIDTH(8)) dut (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .start_i   (start_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .product_o (product_o)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one request, wait for done, check latency (cycles incl. DONE), product, busy.
    task automatic do_mult(input logic [7:0] a, input logic [7:0] b,
                           input int exp_lat, input logic [15:0] exp_p);
        int cyc;
        bit seen;
        bit busy_ok;
        @(negedge clk_in);
        start_i = 1'b1;
        a_i = a;
        b_i = b;
        @(posedge clk_in);
        #1;
        start_i = 1'b0;
        a_i = ~a;
        b_i = ~b;
        cyc = 0;
        seen = 0;
        busy_ok = 1;
        while (!seen && cyc < 400) begin
            @(posedge clk_in);
            #1;
            cyc++;
            if (done_o) seen = 1;
            else if (!busy_o) busy_ok = 0;
        end
        check_val($sformatf("seen_%0dx%0d", a, b), {31'd0, seen}, 32'd1);
        check_val($sformatf("lat_%0dx%0d", a, b), cyc + 1, exp_lat);
        check_val($sformatf("prod_%0dx%0d", a, b), {16'd0, product_o}, {16'd0, exp_p});
        check_val($sformatf("busy_%0dx%0d", a, b), {31'd0, busy_ok}, 32'd1);
        check_val($sformatf("busy_in_done_%0dx%0d", a, b), {31'd0, busy_o}, 32'd0);
        @(posedge clk_in);
        #1;
        check_val($sformatf("done_pulse_%0dx%0d", a, b), {31'd0, done_o}, 32'd0);
        check_val($sformatf("hold_%0dx%0d", a, b), {16'd0, product_o}, {16'd0, exp_p});
    endtask

    initial begin
        int dones;
        int prev;
        int npulse;
        start_i  = 1'b0;
        a_i      = '0;
        b_i      = '0;
        rst_n_in = 1'b0;
        #1;
        check_val("rst_busy", {31'd0, busy_o}, 32'd0);
        check_val("rst_done", {31'd0, done_o}, 32'd0);
        check_val("rst_prod", {16'd0, product_o}, 32'd0);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;

        do_mult(8'd13, 8'd200, 16, 16'd2600);
        do_mult(8'd255, 8'd255, 258, 16'd65025);
        do_mult(8'd1, 8'd255, 4, 16'd255);
        do_mult(8'd0, 8'd77, 2, 16'd0);
        do_mult(8'd77, 8'd0, 2, 16'd0);

        // Request during ACC must be dropped.
        @(negedge clk_in);
        start_i = 1'b1;
        a_i = 8'd6;
        b_i = 8'd7;
        @(posedge clk_in);
        #1;
        start_i = 1'b0;
        dones = 0;
        repeat (3) begin
            @(posedge clk_in);
            #1;
            if (done_o) dones++;
        end
        start_i = 1'b1;
        a_i = 8'd9;
        b_i = 8'd9;
        @(posedge clk_in);
        #1;
        if (done_o) dones++;
        start_i = 1'b0;
        a_i = 8'd200;
        repeat (25) begin
            @(posedge clk_in);
            #1;
            if (done_o) begin
                dones++;
                check_val("drop_prod", {16'd0, product_o}, 32'd42);
            end
            a_i = ~a_i;
        end
        check_val("drop_dones", dones, 1);
        check_val("drop_final", {16'd0, product_o}, 32'd42);

        // Back-to-back with start held high: done every 7 cycles, one IDLE between.
        @(negedge clk_in);
        start_i = 1'b1;
        a_i = 8'd3;
        b_i = 8'd4;
        prev = -1;
        npulse = 0;
        for (int k = 0; k < 26; k++) begin
            @(posedge clk_in);
            #1;
            if (done_o) begin
                npulse++;
                check_val("b2b_prod", {16'd0, product_o}, 32'd12);
                if (prev < 0) check_val("b2b_first", k, 5);
                else check_val("b2b_gap", k - prev, 7);
                prev = k;
                @(posedge clk_in);
                #1;
                k++;
                check_val("b2b_idle", {30'd0, busy_o, done_o}, 32'd0);
            end
        end
        check_val("b2b_count", npulse, 3);
        @(negedge clk_in);
        start_i = 1'b0;
        repeat (8) @(posedge clk_in);

        // Asynchronous reset mid-ACC.
        @(negedge clk_in);
        start_i = 1'b1;
        a_i = 8'd100;
        b_i = 8'd50;
        @(posedge clk_in);
        #1;
        start_i = 1'b0;
        repeat (10) @(posedge clk_in);
        #3;
        check_val("pre_rst_busy", {31'd0, busy_o}, 32'd1);
        rst_n_in = 1'b0;
        #1;
        check_val("arst_busy", {31'd0, busy_o}, 32'd0);
        check_val("arst_done", {31'd0, done_o}, 32'd0);
        check_val("arst_prod", {16'd0, product_o}, 32'd0);
        @(posedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        dones = 0;
        repeat (60) begin
            @(posedge clk_in);
            #1;
            if (done_o || busy_o) dones++;
        end
        check_val("arst_no_resume", dones, 0);
        do_mult(8'd5, 8'd5, 8, 16'd25);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
